// File: rtl/jtag_driver.sv
// jtag_driver: JTAG host that runs whole TAP operations (reset, IR scan,
// DR scan, Run-Test/Idle clocking) as single commands. TCK, TMS and TDI are
// generated from clk; TDO is collected into dout, LSB first.
module jtag_driver #(
    parameter int DIV     = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [5:0]         len,
    input  logic [MAX_LEN-1:0] din,
    output logic               busy,
    output logic               done,
    output logic [MAX_LEN-1:0] dout,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int KW = $clog2(MAX_LEN + 7);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [1:0]         cmd_q;
    logic [KW-1:0]      len_q;
    logic [KW-1:0]      k_q;
    logic [DW-1:0]      dcnt_q;
    logic [MAX_LEN-1:0] din_q;
    logic [MAX_LEN-1:0] dout_q;
    logic               busy_q;
    logic               done_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;

    logic [31:0]        len_w;
    logic [31:0]        k_w;
    logic [31:0]        n_w;
    logic               shift_w;
    logic [31:0]        in_len_w;
    logic [31:0]        in_n_w;

    // Requested length limited to the dout width.
    function automatic logic [31:0] clamp_len(input logic [5:0] l);
        if (32'(l) > 32'(MAX_LEN)) return 32'(MAX_LEN);
        return 32'(l);
    endfunction

    // Number of TCK cycles a command takes; zero-length scans do nothing.
    function automatic logic [31:0] num_cycles(input logic [1:0] c, input logic [31:0] l);
        case (c)
            2'b00:   return 32'd6;
            2'b01:   return (l == '0) ? '0 : l + 32'd6;
            2'b10:   return (l == '0) ? '0 : l + 32'd5;
            default: return l;
        endcase
    endfunction

    // TCK cycles spent walking from Idle into the Shift state.
    function automatic logic [31:0] pre_len(input logic [1:0] c);
        case (c)
            2'b01:   return 32'd4;
            2'b10:   return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [1:0] c, input logic [31:0] l,
                                      input logic [31:0] k);
        logic [31:0] p;
        p = pre_len(c);
        return (c == 2'b01 || c == 2'b10) && (l != '0) && (k >= p) && (k < p + l);
    endfunction

    // TMS for TCK cycle k: entry path, shift (exit on last bit), Update, Idle.
    function automatic logic tms_at(input logic [1:0] c, input logic [31:0] l,
                                    input logic [31:0] k);
        logic [31:0] p;
        p = pre_len(c);
        case (c)
            2'b00: return k < 32'd5;
            2'b01, 2'b10: begin
                if (k < p) return (c == 2'b01) ? (k < 32'd2) : (k == '0);
                if (k < p + l) return k == p + l - 32'd1;
                return k == p + l;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic tdi_at(input logic [1:0] c, input logic [31:0] l,
                                    input logic [31:0] k, input logic [MAX_LEN-1:0] d);
        logic r;
        r = 1'b0;
        if (is_shift(c, l, k)) begin
            for (int unsigned b = 0; b < MAX_LEN; b++) begin
                if (32'(b) == k - pre_len(c)) r = d[b];
            end
        end
        return r;
    endfunction

    // Decode of the latched command and the incoming request.
    always_comb begin
        len_w    = 32'(len_q);
        k_w      = 32'(k_q);
        n_w      = num_cycles(cmd_q, len_w);
        shift_w  = is_shift(cmd_q, len_w, k_w);
        in_len_w = clamp_len(len);
        in_n_w   = num_cycles(cmd, in_len_w);
    end

    // Command FSM with TCK divider; all TAP pins and status are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            case (state_q)
                // FIN is the done-pulse clk; it accepts a new start like IDLE.
                S_IDLE, S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        cmd_q   <= cmd;
                        len_q   <= KW'(in_len_w);
                        din_q   <= din;
                        dout_q  <= '0;
                        busy_q  <= 1'b1;
                        tck_q   <= 1'b0;
                        k_q     <= '0;
                        dcnt_q  <= '0;
                        tms_q   <= (in_n_w == '0) ? 1'b0 : tms_at(cmd, in_len_w, '0);
                        tdi_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                // LOAD is also the first low clk of TCK cycle 0.
                S_LOAD, S_RUN: begin
                    if (state_q == S_LOAD && n_w == '0) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tms_q   <= 1'b0;
                    end else begin
                        state_q <= S_RUN;
                        if (tck_q && dcnt_q == '0 && shift_w) begin
                            for (int unsigned b = 0; b < MAX_LEN; b++) begin
                                if (32'(b) == k_w - pre_len(cmd_q)) dout_q[b] <= TDO;
                            end
                        end
                        if (dcnt_q == DW'(DIV - 1)) begin
                            dcnt_q <= '0;
                            if (!tck_q) begin
                                tck_q <= 1'b1;
                            end else if (k_w == n_w - 32'd1) begin
                                state_q <= S_FIN;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                tck_q   <= 1'b0;
                                tms_q   <= 1'b0;
                                tdi_q   <= 1'b0;
                            end else begin
                                k_q   <= k_q + 1'b1;
                                tck_q <= 1'b0;
                                tms_q <= tms_at(cmd_q, len_w, k_w + 32'd1);
                                tdi_q <= tdi_at(cmd_q, len_w, k_w + 32'd1, din_q);
                            end
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign TCK  = tck_q;
    assign TMS  = tms_q;
    assign TDI  = tdi_q;

endmodule

// File: tb/tb_jtag_driver.sv
// Self-checking bench for jtag_driver: table of directed commands, a reset
// abort sequence, then random commands checked against a path-level model.
module tb_jtag_driver;
    localparam int DIV = 2;
    localparam int ML  = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, TCK, TMS, TDI, TDO;
    logic [1:0]    cmd;
    logic [5:0]    len;
    logic [ML-1:0] din, dout;
    logic          loop_en, tdo_r;
    logic          tdo_bits [0:63];

    int total  = 0;
    int passed = 0;
    bit exp_tms[$];
    bit exp_tdi[$];

    assign TDO = loop_en ? TDI : tdo_r;
    always #5 clk = ~clk;

    jtag_driver #(.DIV(DIV), .MAX_LEN(ML)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .len(len), .din(din),
        .busy(busy), .done(done), .dout(dout), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    typedef struct {
        logic [1:0]  c;
        logic [5:0]  l;
        logic [31:0] d;
        logic        lp;
        bit          b2b;
        int          inj;
        int          n;
        logic [31:0] dout;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic push(input bit m, input bit t);
        exp_tms.push_back(m);
        exp_tdi.push_back(t);
    endtask

    // TAP walk per command: Idle -> ... -> Shift -> Exit1 -> Update -> Idle.
    task automatic build_expect(input logic [1:0] c, input logic [5:0] l_in, input logic [31:0] d);
        int L;
        L = (l_in > 6'd32) ? 32 : int'(l_in);
        exp_tms.delete();
        exp_tdi.delete();
        case (c)
            2'd0: for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
            2'd1, 2'd2: if (L > 0) begin
                if (c == 2'd1) begin push(1, 0); push(1, 0); push(0, 0); push(0, 0); end
                else begin push(1, 0); push(0, 0); push(0, 0); end
                for (int i = 0; i < L; i++) push(i == L - 1, d[i]);
                push(1, 0);
                push(0, 0);
            end
            default: for (int i = 0; i < L; i++) push(0, 0);
        endcase
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] c, input logic [5:0] l_in,
                                               input logic [31:0] d, input logic lp);
        logic [31:0] r;
        int L, pre;
        r   = '0;
        L   = (l_in > 6'd32) ? 32 : int'(l_in);
        pre = (c == 2'd1) ? 4 : 3;
        if (c == 2'd1 || c == 2'd2)
            for (int i = 0; i < L; i++) r[i] = lp ? d[i] : tdo_bits[pre + i];
        return r;
    endfunction

    // Issue one command and watch it clk by clk until done (bounded).
    task automatic run_cmd(input string nm, input logic [1:0] c, input logic [5:0] l,
                           input logic [31:0] d, input logic lp, input int exp_n,
                           input logic [31:0] exp_dout, input bit b2b, input int inj);
        int done_clk, busy_bad, unstable, fall_cnt, budget, exp_done, nk;
        int rise_clk[$];
        bit rtms[$];
        bit rtdi[$];
        logic ptck, ptms, ptdi, fell;
        done_clk = -1; busy_bad = 0; unstable = 0; fall_cnt = 0;
        if (!b2b) begin
            @(negedge clk);
            chk({nm, "/done_width"}, 64'(done), 64'd0);
        end
        loop_en = lp;
        tdo_r   = tdo_bits[0];
        start = 1'b1; cmd = c; len = l; din = d;
        @(posedge clk);
        #1 start = 1'b0;
        ptck = 1'b0; ptms = TMS; ptdi = TDI;
        budget = 2 * DIV * (exp_n + 2) + 8;
        for (int cc = 1; cc <= budget; cc++) begin
            @(negedge clk);
            if (inj != 0 && cc == inj) begin start = 1'b1; cmd = 2'b00; end
            else if (inj != 0 && cc == inj + 1) start = 1'b0;
            if (done) begin done_clk = cc; break; end
            if (!busy) busy_bad++;
            fell = ptck && !TCK;
            if (cc > 1 && !fell && (TMS !== ptms || TDI !== ptdi)) unstable++;
            if (TCK && !ptck) begin
                rise_clk.push_back(cc);
                rtms.push_back(TMS);
                rtdi.push_back(TDI);
            end
            if (fell) begin
                fall_cnt++;
                if (fall_cnt < 64) tdo_r = tdo_bits[fall_cnt];
            end
            ptck = TCK; ptms = TMS; ptdi = TDI;
        end
        start = 1'b0;
        exp_done = (exp_n == 0) ? 2 : 1 + 2 * DIV * exp_n;
        chk({nm, "/done_clk"}, 64'(done_clk), 64'(exp_done));
        chk({nm, "/tck_count"}, 64'(rise_clk.size()), 64'(exp_n));
        nk = (rise_clk.size() < exp_tms.size()) ? rise_clk.size() : exp_tms.size();
        for (int k = 0; k < nk; k++) begin
            chk($sformatf("%s/tms%0d", nm, k), 64'(rtms[k]), 64'(exp_tms[k]));
            chk($sformatf("%s/tdi%0d", nm, k), 64'(rtdi[k]), 64'(exp_tdi[k]));
            chk($sformatf("%s/rise%0d", nm, k), 64'(rise_clk[k]), 64'(1 + 2 * DIV * k + DIV));
        end
        chk({nm, "/busy_gap"}, 64'(busy_bad), 64'd0);
        chk({nm, "/pin_glitch"}, 64'(unstable), 64'd0);
        chk({nm, "/park"}, 64'({TCK, TMS, TDI, busy}), 64'd0);
        chk({nm, "/dout"}, 64'(dout), 64'(exp_dout));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rc;
        logic [5:0]  rl;
        logic [31:0] rd;
        logic        rlp;
        bit          rb, dseen;

        tbl[0]  = '{2'b00, 6'd0,  32'h0,        1'b0, 1'b0, 0,  6,  32'h0};
        tbl[1]  = '{2'b01, 6'd4,  32'h7,        1'b1, 1'b0, 0,  10, 32'h7};
        tbl[2]  = '{2'b10, 6'd8,  32'hA5,       1'b1, 1'b1, 0,  13, 32'hA5};
        tbl[3]  = '{2'b10, 6'd40, 32'hDEADBEEF, 1'b1, 1'b0, 20, 37, 32'hDEADBEEF};
        tbl[4]  = '{2'b11, 6'd3,  32'hFFFFFFFF, 1'b1, 1'b0, 0,  3,  32'h0};
        tbl[5]  = '{2'b11, 6'd0,  32'hFFFFFFFF, 1'b1, 1'b1, 0,  0,  32'h0};
        tbl[6]  = '{2'b01, 6'd0,  32'h0000FFFF, 1'b1, 1'b0, 0,  0,  32'h0};
        tbl[7]  = '{2'b10, 6'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 0,  6,  32'h1};
        tbl[8]  = '{2'b01, 6'd32, 32'h12345678, 1'b1, 1'b1, 0,  38, 32'h12345678};
        tbl[9]  = '{2'b10, 6'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 0,  36, 32'h7FFFFFFF};
        tbl[10] = '{2'b00, 6'd9,  32'hFFFFFFFF, 1'b1, 1'b1, 0,  6,  32'h0};

        rst_n = 1'b0; start = 1'b0; cmd = '0; len = '0; din = '0;
        loop_en = 1'b0; tdo_r = 1'b0;
        for (int i = 0; i < 64; i++) tdo_bits[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/pins", 64'({TCK, TMS, TDI, busy, done}), 64'b01000);
        chk("reset/dout", 64'(dout), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            build_expect(tbl[i].c, tbl[i].l, tbl[i].d);
            run_cmd($sformatf("vec%0d", i), tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].lp,
                    tbl[i].n, tbl[i].dout, tbl[i].b2b, tbl[i].inj);
        end

        // Abort a DR scan at TCK cycle 5 (clk 21 with DIV=2).
        @(negedge clk);
        start = 1'b1; cmd = 2'b10; len = 6'd8; din = 32'hA5; loop_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (21) @(negedge clk);
        chk("abort/busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort/pins", 64'({TCK, TMS, TDI, busy, done}), 64'b01000);
        chk("abort/dout", 64'(dout), 64'd0);
        dseen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (done) dseen = 1'b1;
        end
        chk("abort/no_done", 64'(dseen), 64'd0);
        build_expect(2'b00, 6'd0, 32'h0);
        run_cmd("abort/reset_cmd", 2'b00, 6'd0, 32'h0, 1'b0, 6, 32'h0, 1'b0, 0);

        for (int r = 0; r < 24; r++) begin
            rc  = 2'($urandom_range(0, 3));
            rl  = 6'($urandom_range(0, 63));
            rd  = $urandom;
            rlp = 1'($urandom_range(0, 1));
            rb  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++) tdo_bits[i] = 1'($urandom_range(0, 1));
            build_expect(rc, rl, rd);
            run_cmd($sformatf("rnd%0d", r), rc, rl, rd, rlp, exp_tms.size(),
                    model_dout(rc, rl, rd, rlp), rb, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
